// File: rtl/bldc_pwm_pkg.sv
// Shared constants for the BLDC complementary PWM block.
package bldc_pwm_pkg;

    localparam int DEF_CW   = 8;
    localparam int DEF_NCH  = 3;
    localparam int DEF_DT_W = 4;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTRE = 1'b1;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/bldc_pwm_3ph_if.sv
// Control/status bundle between the commutation controller (master) and the PWM block (slave).
interface bldc_pwm_3ph_if #(
    parameter int CW   = bldc_pwm_pkg::DEF_CW,
    parameter int NCH  = bldc_pwm_pkg::DEF_NCH,
    parameter int DT_W = bldc_pwm_pkg::DEF_DT_W
);
    logic              enable;
    logic              mode;
    logic [CW-1:0]     period;
    logic [NCH*CW-1:0] duty;
    logic [DT_W-1:0]   dead_time;
    logic              load;
    logic              load_ack;
    logic              period_start;
    logic [NCH-1:0]    pwm_hi;
    logic [NCH-1:0]    pwm_lo;

    modport master (
        output enable, mode, period, duty, dead_time, load,
        input  load_ack, period_start, pwm_hi, pwm_lo
    );

    modport slave (
        input  enable, mode, period, duty, dead_time, load,
        output load_ack, period_start, pwm_hi, pwm_lo
    );
endinterface

// File: rtl/bldc_pwm_3ph_dead_time_gen.sv
// Per-channel dead-time inserter: every raw edge blanks both gates for dead_time cycles.
module dead_time_gen #(
    parameter int DT_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr,
    input  logic            raw,
    input  logic [DT_W-1:0] dead_time,
    output logic            hi,
    output logic            lo
);
    logic            tgt;
    logic            fresh;
    logic [DT_W-1:0] gap;

    // fresh makes the first drive after reset/clear go through a dead window too
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi    <= 1'b0;
            lo    <= 1'b0;
            tgt   <= 1'b0;
            fresh <= 1'b1;
            gap   <= '0;
        end else if (clr) begin
            hi    <= 1'b0;
            lo    <= 1'b0;
            fresh <= 1'b1;
            gap   <= '0;
        end else if (fresh || raw != tgt) begin
            tgt   <= raw;
            fresh <= 1'b0;
            if (dead_time == '0) begin
                hi  <= raw;
                lo  <= ~raw;
                gap <= '0;
            end else begin
                hi  <= 1'b0;
                lo  <= 1'b0;
                gap <= dead_time - 1'b1;
            end
        end else if (gap != '0) begin
            hi  <= 1'b0;
            lo  <= 1'b0;
            gap <= gap - 1'b1;
        end else begin
            hi <= tgt;
            lo <= ~tgt;
        end
    end
endmodule

// File: rtl/bldc_pwm_3ph.sv
// Shared edge/centre PWM counter with double-buffered period/duty/mode and per-channel dead time.
module bldc_pwm_3ph
    import bldc_pwm_pkg::*;
#(
    parameter int CW   = DEF_CW,
    parameter int NCH  = DEF_NCH,
    parameter int DT_W = DEF_DT_W
) (
    input logic           clk,
    input logic           reset_n,
    bldc_pwm_3ph_if.slave bus
);
    logic                    alive;
    logic                    run;
    logic [CW-1:0]           cnt;
    dir_e                    dir;
    logic [CW-1:0]           act_period, pend_period, eff_period;
    logic                    act_mode, pend_mode, eff_mode;
    logic [NCH-1:0][CW-1:0]  act_duty, pend_duty, eff_duty;
    logic                    pend_flag;
    logic                    bnd, apply;
    logic [NCH-1:0]          hi_w, lo_w;

    // alive keeps the first cycle after reset release idle, so no boundary is seen while in reset
    assign run   = bus.enable & alive;
    assign bnd   = run & (cnt == '0);
    assign apply = bnd & pend_flag;

    // In the boundary cycle the pending set already governs the count and compare
    assign eff_period = apply ? pend_period : act_period;
    assign eff_mode   = apply ? pend_mode   : act_mode;
    assign eff_duty   = apply ? pend_duty   : act_duty;

    assign bus.period_start = bnd;
    assign bus.load_ack     = apply;
    assign bus.pwm_hi       = hi_w;
    assign bus.pwm_lo       = lo_w;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alive <= 1'b0;
            cnt   <= '0;
            dir   <= UP;
        end else begin
            alive <= 1'b1;
            if (!run || eff_period == '0) begin
                cnt <= '0;
                dir <= UP;
            end else if (eff_mode == MODE_EDGE) begin
                cnt <= (cnt >= eff_period) ? '0 : cnt + 1'b1;
                dir <= UP;
            end else begin
                case (dir)
                    UP: begin
                        if (cnt >= eff_period - 1'b1) begin
                            cnt <= eff_period;
                            dir <= DOWN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DOWN: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) dir <= UP;
                    end
                endcase
            end
        end
    end

    // A load in a boundary cycle still applies the older pending set; the new one waits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_period  <= '0;
            act_mode    <= MODE_EDGE;
            act_duty    <= '0;
            pend_period <= '0;
            pend_mode   <= MODE_EDGE;
            pend_duty   <= '0;
            pend_flag   <= 1'b0;
        end else begin
            if (apply) begin
                act_period <= pend_period;
                act_mode   <= pend_mode;
                act_duty   <= pend_duty;
            end
            if (bus.load) begin
                pend_period <= bus.period;
                pend_mode   <= bus.mode;
                pend_duty   <= bus.duty;
                pend_flag   <= 1'b1;
            end else if (apply) begin
                pend_flag <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [CW-1:0] d;
        logic          hit;
        logic          raw_q;

        assign d = eff_duty[k];
        // centre duty >= P is forced high so the peak cycle does not glitch low
        assign hit = (d != '0) && ((eff_mode == MODE_CENTRE && d >= eff_period) || cnt < d);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) raw_q <= 1'b0;
            else          raw_q <= run & hit;
        end

        dead_time_gen #(.DT_W(DT_W)) u_dt (
            .clk       (clk),
            .reset_n   (reset_n),
            .clr       (~run),
            .raw       (raw_q),
            .dead_time (bus.dead_time),
            .hi        (hi_w[k]),
            .lo        (lo_w[k])
        );
    end
endmodule

// File: tb/tb_bldc_pwm_3ph.sv
// Randomised scoreboard bench for bldc_pwm_3ph against a phase-based reference model.
module tb_bldc_pwm_3ph;
    localparam int CW   = 8;
    localparam int NCH  = 3;
    localparam int DT_W = 4;

    typedef struct packed {
        logic           ps;
        logic           ack;
        logic [NCH-1:0] hi;
        logic [NCH-1:0] lo;
    } exp_t;

    bit   clk = 1'b0;
    logic reset_n;
    bldc_pwm_3ph_if #(.CW(CW), .NCH(NCH), .DT_W(DT_W)) bus ();

    bldc_pwm_3ph #(.CW(CW), .NCH(NCH), .DT_W(DT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // stimulus state
    bit                s_rst, s_en, s_mode;
    logic [CW-1:0]     s_per;
    logic [NCH*CW-1:0] s_duty;
    logic [DT_W-1:0]   s_dt;

    // reference model state: period phase, active/pending sets, dead-time history
    int m_ph, m_aper, m_pper;
    bit m_amode, m_pmode, m_flag, m_alive;
    int m_aduty[NCH], m_pduty[NCH];
    bit m_raw[NCH], m_hi[NCH], m_lo[NCH], m_fresh[NCH], m_last[NCH];
    int m_tc[NCH], m_dtc[NCH];
    int cyc;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mon_cyc = 0;

    function automatic int plen();
        if (m_aper == 0) return 1;
        return m_amode ? 2 * m_aper : m_aper + 1;
    endfunction

    function automatic int cnt_of(int ph);
        if (!m_amode || ph <= m_aper) return ph;
        return 2 * m_aper - ph;
    endfunction

    function automatic bit raw_rule(int c, int d, int p, bit centre);
        if (d == 0) return 1'b0;
        if (centre && d >= p) return 1'b1;
        return c < d;
    endfunction

    task automatic model_step(input bit ld);
        exp_t e;
        bit   run;
        int   c;
        bit   nraw[NCH];
        e = '0;
        if (!s_rst) begin
            m_ph = 0; m_aper = 0; m_pper = 0; m_amode = 0; m_pmode = 0; m_flag = 0; m_alive = 0;
            for (int k = 0; k < NCH; k++) begin
                m_aduty[k] = 0; m_pduty[k] = 0; m_raw[k] = 0;
                m_hi[k] = 0; m_lo[k] = 0; m_fresh[k] = 1; m_last[k] = 0;
            end
            q.push_back(e);
            cyc++;
            return;
        end
        run = s_en && m_alive;
        for (int k = 0; k < NCH; k++) nraw[k] = 1'b0;
        if (run) begin
            if (m_ph == 0) begin
                e.ps = 1'b1;
                if (m_flag) begin
                    e.ack = 1'b1; m_flag = 0;
                    m_aper = m_pper; m_amode = m_pmode;
                    for (int k = 0; k < NCH; k++) m_aduty[k] = m_pduty[k];
                end
            end
            c = cnt_of(m_ph);
            for (int k = 0; k < NCH; k++) nraw[k] = raw_rule(c, m_aduty[k], m_aper, m_amode);
            m_ph = (m_ph + 1) % plen();
        end else begin
            m_ph = 0;
        end
        if (ld) begin
            m_pper = int'(s_per); m_pmode = s_mode; m_flag = 1;
            for (int k = 0; k < NCH; k++) m_pduty[k] = int'(s_duty[k*CW +: CW]);
        end
        for (int k = 0; k < NCH; k++) begin
            e.hi[k] = m_hi[k];
            e.lo[k] = m_lo[k];
        end
        q.push_back(e);
        for (int k = 0; k < NCH; k++) begin
            if (!run) begin
                m_hi[k] = 0; m_lo[k] = 0; m_fresh[k] = 1;
            end else begin
                if (m_fresh[k] || m_raw[k] != m_last[k]) begin
                    m_tc[k] = cyc; m_dtc[k] = int'(s_dt); m_fresh[k] = 0;
                end
                m_last[k] = m_raw[k];
                if (cyc + 1 - m_tc[k] <= m_dtc[k]) begin
                    m_hi[k] = 0; m_lo[k] = 0;
                end else begin
                    m_hi[k] = m_last[k]; m_lo[k] = !m_last[k];
                end
            end
            m_raw[k] = nraw[k];
        end
        m_alive = 1;
        cyc++;
    endtask

    task automatic tick(input bit ld);
        @(posedge clk);
        #1;
        reset_n       = s_rst;
        bus.enable    = s_en;
        bus.mode      = s_mode;
        bus.period    = s_per;
        bus.duty      = s_duty;
        bus.dead_time = s_dt;
        bus.load      = ld;
        model_step(ld);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic set_duty(input int d0, input int d1, input int d2);
        s_duty[0*CW +: CW] = CW'(d0);
        s_duty[1*CW +: CW] = CW'(d1);
        s_duty[2*CW +: CW] = CW'(d2);
    endtask

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, mon_cyc, got, want);
        end
    endtask

    // monitor: every cycle is an output beat; pop and compare at the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("period_start", int'(bus.period_start), int'(e.ps));
            check("load_ack",     int'(bus.load_ack),     int'(e.ack));
            check("pwm_hi",       int'(bus.pwm_hi),       int'(e.hi));
            check("pwm_lo",       int'(bus.pwm_lo),       int'(e.lo));
            check("no_overlap",   int'(bus.pwm_hi & bus.pwm_lo), 0);
            mon_cyc++;
        end
    end

    initial begin
        reset_n = 1'b0;
        bus.enable = 1'b0; bus.mode = 1'b0; bus.period = '0;
        bus.duty = '0; bus.dead_time = '0; bus.load = 1'b0;
        s_rst = 0; s_en = 0; s_mode = 0; s_per = '0; s_duty = '0; s_dt = '0;
        cyc = 0;
        ticks(3);
        s_rst = 1;
        ticks(3);

        // edge P=9, duty0=3, no dead time
        s_per = 8'd9; s_mode = 1'b0; set_duty(3, 7, 10); s_dt = '0;
        tick(1'b1);
        s_en = 1;
        ticks(40);

        // centre P=8, duty 4
        s_per = 8'd8; s_mode = 1'b1; set_duty(4, 8, 1);
        tick(1'b1);
        ticks(50);

        // dead time 3, duty 5 then 2 loaded mid-period
        s_per = 8'd9; s_mode = 1'b0; s_dt = 4'd3; set_duty(5, 5, 5);
        tick(1'b1);
        ticks(34);
        set_duty(2, 2, 2);
        tick(1'b1);
        ticks(30);

        // extremes: duty 0, duty P+1, duty max; then P=0 in both modes
        s_dt = 4'd1; set_duty(0, 10, 255);
        tick(1'b1);
        ticks(30);
        s_per = 8'd0; set_duty(0, 1, 7);
        tick(1'b1);
        ticks(12);
        s_mode = 1'b1;
        tick(1'b1);
        ticks(12);

        // reset pulse mid-period, then enable dropped for 5 cycles
        s_per = 8'd9; s_mode = 1'b0; s_dt = 4'd2; set_duty(4, 6, 3);
        tick(1'b1);
        ticks(16);
        s_rst = 0; ticks(2); s_rst = 1;
        tick(1'b1);
        ticks(15);
        s_en = 0; ticks(5); s_en = 1;
        ticks(25);

        // two loads in one period: only the last duty applies, single ack
        s_per = 8'd30; s_dt = 4'd0; set_duty(10, 10, 10);
        tick(1'b1);
        ticks(40);
        set_duty(10, 11, 12); tick(1'b1);
        ticks(5);
        set_duty(20, 21, 22); tick(1'b1);
        ticks(40);

        // randomised segments
        for (int s = 0; s < 40; s++) begin
            int p;
            int n;
            p = $urandom_range(0, 20);
            s_per = CW'(p);
            s_mode = 1'($urandom_range(0, 1));
            for (int k = 0; k < NCH; k++) s_duty[k*CW +: CW] = CW'($urandom_range(0, p + 2));
            s_dt = DT_W'($urandom_range(0, 4));
            s_en = ($urandom_range(0, 7) != 0);
            if (s == 20) begin
                s_rst = 0; tick(1'b0); s_rst = 1;
            end
            tick(1'b1);
            n = $urandom_range(10, 50);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 15) == 0) s_dt = DT_W'($urandom_range(0, 4));
                if ($urandom_range(0, 40) == 0) s_en = !s_en;
                if ($urandom_range(0, 20) == 0)
                    for (int k = 0; k < NCH; k++) s_duty[k*CW +: CW] = CW'($urandom_range(0, p + 2));
                tick($urandom_range(0, 20) == 0);
            end
        end

        bus.load = 1'b0;
        repeat (3) @(posedge clk);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
